// File: rtl/snowbro2_bank_resp.sv
// snowbro2_bank_resp
// Memory-side responder for the snowbro2 SDRAM request interface. Serialises
// ROM-download writes (prog_*) and four-bank read requests plus bank-0 writes
// (ba_*) onto one synchronous, fixed-latency, 16-bit memory port.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   downloading_i          ROM download in progress (bank requests ignored)
//   prog_*_i / prog_rdy_o  download write request (level) / done (pulse)
//   baN_addr_i, ba_rd_i    per-bank word address / request (level)
//   ba_wr_i, ba0_din*_i    turn a bank-0 request into a masked write
//   ba_ack/dst/dok/rdy_o   accept, first word, data valid, complete (per bank)
//   data_read_o            read data (memory data registered once)
//   mem_*                  memory port: {bank, word} address, strobes, data
//   dbg_state_o            current FSM state
//
// Handshake: a request is a level. It is sampled only while the FSM is idle;
// ACK pulses once when it is accepted (address already captured), RDY pulses
// once when the transaction is complete. A request still high after RDY is a
// new request; one dropped before ACK is never granted.
module snowbro2_bank_resp #(
    parameter int MEM_LAT = 2,  // MEM_RD to MEM_DOUT valid, 1..4 cycles
    parameter int BURST   = 2   // words per read, 1 or 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        downloading_i,
    input  logic [21:0] prog_addr_i,
    input  logic [15:0] prog_data_i,
    input  logic [1:0]  prog_mask_i,
    input  logic [1:0]  prog_ba_i,
    input  logic        prog_we_i,
    output logic        prog_rdy_o,
    input  logic [21:0] ba0_addr_i,
    input  logic [21:0] ba1_addr_i,
    input  logic [21:0] ba2_addr_i,
    input  logic [21:0] ba3_addr_i,
    input  logic [3:0]  ba_rd_i,
    input  logic        ba_wr_i,
    input  logic [15:0] ba0_din_i,
    input  logic [1:0]  ba0_din_m_i,
    output logic [3:0]  ba_ack_o,
    output logic [3:0]  ba_dst_o,
    output logic [3:0]  ba_dok_o,
    output logic [3:0]  ba_rdy_o,
    output logic [15:0] data_read_o,
    output logic [23:0] mem_addr_o,
    output logic        mem_rd_o,
    output logic        mem_we_o,
    output logic [15:0] mem_din_o,
    output logic [1:0]  mem_wmask_o,
    input  logic [15:0] mem_dout_i,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PWR      = 3'd1,
        S_BWR      = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_DRAIN = 3'd4
    } state_e;

    localparam logic LAST_BEAT = 1'(BURST - 1);

    state_e       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   bank_q, bank_d;
    logic         is_wr_q, is_wr_d;
    logic [21:0]  addr_q, addr_d;
    logic [15:0]  din_q, din_d;
    logic [1:0]   wmask_q, wmask_d;
    logic         beat_q, beat_d;
    logic         blank_q;
    logic [15:0]  data_q;
    // Read-tag pipeline: bit k is the MEM_RD of k+1 cycles ago.
    logic [MEM_LAT:0] v_q, first_q, last_q;

    logic [21:0]  ba_addr [4];
    logic         grant_vld;
    logic [1:0]   grant_idx, cand;
    logic [3:0]   bank_oh;
    logic         rd_last;

    assign ba_addr[0] = ba0_addr_i;
    assign ba_addr[1] = ba1_addr_i;
    assign ba_addr[2] = ba2_addr_i;
    assign ba_addr[3] = ba3_addr_i;

    assign bank_oh     = 4'b0001 << bank_q;
    assign rd_last     = v_q[MEM_LAT] & last_q[MEM_LAT];
    assign data_read_o = data_q;
    assign dbg_state_o = state_q;

    // Round-robin search: walking offsets from high to low lets the closest
    // request to the pointer win without an early loop exit.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        cand      = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (ba_rd_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        bank_d  = bank_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        wmask_d = wmask_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                beat_d = 1'b0;
                // The loader drops PROG_WE one edge late, so the cycle right
                // after a PROG write must not see it as a new request.
                if (prog_we_i && !blank_q) begin
                    state_d = S_PWR;
                    bank_d  = prog_ba_i;
                    addr_d  = prog_addr_i;
                    din_d   = prog_data_i;
                    wmask_d = prog_mask_i;
                    is_wr_d = 1'b1;
                end else if (!downloading_i && grant_vld) begin
                    bank_d = grant_idx;
                    addr_d = ba_addr[grant_idx];
                    ptr_d  = grant_idx + 2'd1;
                    if (grant_idx == 2'd0 && ba_wr_i) begin
                        state_d = S_BWR;
                        is_wr_d = 1'b1;
                        din_d   = ba0_din_i;
                        wmask_d = ba0_din_m_i;
                    end else begin
                        state_d = S_RD_ISSUE;
                        is_wr_d = 1'b0;
                    end
                end
            end
            S_PWR: state_d = S_IDLE;
            // Bank-0 write reuses the drain state to place RDY one cycle later.
            S_BWR: state_d = S_RD_DRAIN;
            S_RD_ISSUE: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = S_RD_DRAIN;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            S_RD_DRAIN: begin
                if (is_wr_q || rd_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prog_rdy_o  = 1'b0;
        ba_ack_o    = 4'b0;
        ba_dst_o    = 4'b0;
        ba_dok_o    = 4'b0;
        ba_rdy_o    = 4'b0;
        mem_addr_o  = 24'b0;
        mem_rd_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_din_o   = 16'b0;
        mem_wmask_o = 2'b0;
        case (state_q)
            S_PWR, S_BWR: begin
                mem_we_o    = 1'b1;
                mem_addr_o  = {bank_q, addr_q};
                mem_din_o   = din_q;
                mem_wmask_o = wmask_q;
                prog_rdy_o  = (state_q == S_PWR);
                ba_ack_o    = (state_q == S_BWR) ? bank_oh : 4'b0;
            end
            S_RD_ISSUE: begin
                mem_rd_o   = 1'b1;
                // Word address wraps inside the bank.
                mem_addr_o = {bank_q, addr_q + 22'(beat_q)};
                ba_ack_o   = (beat_q == 1'b0) ? bank_oh : 4'b0;
            end
            S_RD_DRAIN: begin
                ba_rdy_o = is_wr_q ? bank_oh : 4'b0;
            end
            default: ;
        endcase
        if (v_q[MEM_LAT]) begin
            ba_dok_o = bank_oh;
            ba_dst_o = first_q[MEM_LAT] ? bank_oh : 4'b0;
            ba_rdy_o = last_q[MEM_LAT] ? bank_oh : 4'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'b0;
            bank_q  <= 2'b0;
            is_wr_q <= 1'b0;
            addr_q  <= 22'b0;
            din_q   <= 16'b0;
            wmask_q <= 2'b0;
            beat_q  <= 1'b0;
            blank_q <= 1'b0;
            data_q  <= 16'b0;
            v_q     <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            bank_q  <= bank_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            wmask_q <= wmask_d;
            beat_q  <= beat_d;
            blank_q <= (state_q == S_PWR);
            v_q     <= {v_q[MEM_LAT-1:0], mem_rd_o};
            first_q <= {first_q[MEM_LAT-1:0], mem_rd_o & (beat_q == 1'b0)};
            last_q  <= {last_q[MEM_LAT-1:0], mem_rd_o & (beat_q == LAST_BEAT)};
            // Memory data is valid MEM_LAT cycles after its strobe.
            if (v_q[MEM_LAT-1]) begin
                data_q <= mem_dout_i;
            end
        end
    end

endmodule

// File: tb/tb_snowbro2_bank_resp.sv
module tb_snowbro2_bank_resp;
  localparam int LAT   = 2;
  localparam int BURST = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        downloading_i;
  logic [21:0] prog_addr_i;
  logic [15:0] prog_data_i;
  logic [1:0]  prog_mask_i;
  logic [1:0]  prog_ba_i;
  logic        prog_we_i;
  logic        prog_rdy_o;
  logic [21:0] ba0_addr_i, ba1_addr_i, ba2_addr_i, ba3_addr_i;
  logic [3:0]  ba_rd_i;
  logic        ba_wr_i;
  logic [15:0] ba0_din_i;
  logic [1:0]  ba0_din_m_i;
  logic [3:0]  ba_ack_o, ba_dst_o, ba_dok_o, ba_rdy_o;
  logic [15:0] data_read_o;
  logic [23:0] mem_addr_o;
  logic        mem_rd_o, mem_we_o;
  logic [15:0] mem_din_o;
  logic [1:0]  mem_wmask_o;
  logic [15:0] mem_dout_i;
  logic [2:0]  dbg_state_o;

  snowbro2_bank_resp #(.MEM_LAT(LAT), .BURST(BURST)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .downloading_i(downloading_i),
    .prog_addr_i(prog_addr_i), .prog_data_i(prog_data_i), .prog_mask_i(prog_mask_i),
    .prog_ba_i(prog_ba_i), .prog_we_i(prog_we_i), .prog_rdy_o(prog_rdy_o),
    .ba0_addr_i(ba0_addr_i), .ba1_addr_i(ba1_addr_i), .ba2_addr_i(ba2_addr_i),
    .ba3_addr_i(ba3_addr_i), .ba_rd_i(ba_rd_i), .ba_wr_i(ba_wr_i),
    .ba0_din_i(ba0_din_i), .ba0_din_m_i(ba0_din_m_i), .ba_ack_o(ba_ack_o),
    .ba_dst_o(ba_dst_o), .ba_dok_o(ba_dok_o), .ba_rdy_o(ba_rdy_o),
    .data_read_o(data_read_o), .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o),
    .mem_we_o(mem_we_o), .mem_din_o(mem_din_o), .mem_wmask_o(mem_wmask_o),
    .mem_dout_i(mem_dout_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [41:0] exp_wr_q[$];  // {addr24, din16, mask2}
  logic [19:0] exp_rd_q[$];  // {bank2, data16, dst, rdy}

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm, input logic [63:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h with nothing expected", nm, act);
  endtask

  function automatic logic [15:0] mem_word(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]} ^ 16'h5A3C;
  endfunction

  function automatic int oh2i(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v == (4'b0001 << i)) r = i;
    return r;
  endfunction

  // ---------------- memory model: fixed latency LAT ----------------
  logic        hv [0:LAT];
  logic [23:0] ha [0:LAT];
  always @(negedge clk_i) begin
    for (int k = LAT; k > 0; k--) begin
      hv[k] = hv[k-1];
      ha[k] = ha[k-1];
    end
    hv[0] = mem_rd_o;
    ha[0] = mem_addr_o;
    mem_dout_i = (hv[LAT] === 1'b1) ? mem_word(ha[LAT]) : 16'hDEAD;
  end

  // ---------------- monitor: pops expected writes / read words ----------------
  always @(negedge clk_i) begin
    logic [41:0] w;
    logic [19:0] r;
    logic [3:0]  oh;
    if (rst_ni) begin
      if (mem_we_o) begin
        if (exp_wr_q.size() == 0) flag("unexpected_write", {mem_addr_o, mem_din_o, mem_wmask_o});
        else begin
          w = exp_wr_q.pop_front();
          check("mem_write", {22'b0, mem_addr_o, mem_din_o, mem_wmask_o}, {22'b0, w});
        end
      end
      if (ba_dok_o != 4'b0) begin
        if (exp_rd_q.size() == 0) flag("unexpected_dok", {ba_dok_o, data_read_o});
        else begin
          r  = exp_rd_q.pop_front();
          oh = 4'b0001 << r[19:18];
          check("rd_data", data_read_o, r[17:2]);
          check("rd_dok", ba_dok_o, oh);
          check("rd_dst", ba_dst_o, r[1] ? oh : 4'b0);
          check("rd_rdy", ba_rdy_o, r[0] ? oh : 4'b0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ba_addr(input int b, input logic [21:0] a);
    case (b)
      0: ba0_addr_i = a;
      1: ba1_addr_i = a;
      2: ba2_addr_i = a;
      default: ba3_addr_i = a;
    endcase
  endtask

  task automatic push_read(input int b, input logic [23:0] e0, input logic [23:0] e1);
    exp_rd_q.push_back({2'(b), mem_word(e0), 1'b1, 1'b0});
    exp_rd_q.push_back({2'(b), mem_word(e1), 1'b0, 1'b1});
  endtask

  task automatic do_read(input int b, input logic [21:0] a, input logic [23:0] e0, input logic [23:0] e1);
    int t0, ack_c, dst_c, rdy_c, nrd;
    logic [23:0] ga [2];
    logic [3:0]  ack_v;
    ack_c = -1; dst_c = -1; rdy_c = -1; nrd = 0;
    ga[0] = '0; ga[1] = '0; ack_v = '0;
    @(posedge clk_i); #1;
    set_ba_addr(b, a);
    push_read(b, e0, e1);
    ba_rd_i[b] = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 30 && rdy_c < 0; k++) begin
      @(negedge clk_i);
      if (mem_rd_o) begin
        if (nrd < 2) ga[nrd] = mem_addr_o;
        nrd++;
      end
      if (ba_ack_o != 4'b0 && ack_c < 0) begin
        ack_c = cyc - t0;
        ack_v = ba_ack_o;
        ba_rd_i[b] = 1'b0;
        set_ba_addr(b, a ^ 22'h155555);  // address may change after ACK
      end
      if (ba_dst_o != 4'b0 && dst_c < 0) dst_c = cyc - t0;
      if (ba_rdy_o != 4'b0) rdy_c = cyc - t0;
    end
    ba_rd_i[b] = 1'b0;
    check("rd_ack_cycle", 64'(ack_c), 64'(1));
    check("rd_ack_vec", ack_v, 4'b0001 << b);
    check("rd_addr0", ga[0], e0);
    check("rd_addr1", ga[1], e1);
    check("rd_strobes", 64'(nrd), 64'(BURST));
    check("rd_dst_cycle", 64'(dst_c), 64'(LAT + 2));
    check("rd_rdy_cycle", 64'(rdy_c), 64'(LAT + BURST + 1));
    @(negedge clk_i);
  endtask

  // ---------------- read vector table ----------------
  typedef struct {
    int          bank;
    logic [21:0] addr;
    logic [23:0] exp_a0;
    logic [23:0] exp_a1;
  } vec_t;

  vec_t vecs [5];

  // ---------------- main test ----------------
  initial begin
    int t0, cnt, nack, nrdy, last_rdy, got, ack_c, rdy_c, dok_seen;
    int order [5];
    int gap [5];
    int rdy_t [6];
    logic [3:0] ack_v, rdy_v;
    logic [21:0] pa;
    logic [15:0] pd;
    logic [1:0]  pm;

    vecs[0] = '{1, 22'h3FFFFF, 24'h7FFFFF, 24'h400000};
    vecs[1] = '{0, 22'h000000, 24'h000000, 24'h000001};
    vecs[2] = '{2, 22'h123456, 24'h923456, 24'h923457};
    vecs[3] = '{3, 22'h2AAAAA, 24'hEAAAAA, 24'hEAAAAB};
    vecs[4] = '{3, 22'h3FFFFF, 24'hFFFFFF, 24'hC00000};

    rst_ni = 1'b0;
    downloading_i = 1'b0;
    prog_addr_i = '0; prog_data_i = '0; prog_mask_i = '0; prog_ba_i = '0; prog_we_i = 1'b0;
    ba0_addr_i = '0; ba1_addr_i = '0; ba2_addr_i = '0; ba3_addr_i = '0;
    ba_rd_i = '0; ba_wr_i = 1'b0; ba0_din_i = '0; ba0_din_m_i = '0;

    // reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ctrl", {ba_ack_o, ba_dst_o, ba_dok_o, ba_rdy_o, prog_rdy_o, mem_rd_o, mem_we_o, mem_wmask_o}, 64'h0);
    check("reset_data", {data_read_o, mem_addr_o, mem_din_o}, 64'h0);
    check("reset_state", dbg_state_o, 3'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // table-driven single reads
    for (int i = 0; i < 5; i++) do_read(vecs[i].bank, vecs[i].addr, vecs[i].exp_a0, vecs[i].exp_a1);

    // reset in the middle of a read, while the first word is on DATA_READ
    @(posedge clk_i); #1;
    ba2_addr_i = 22'h000100;
    ba_rd_i[2] = 1'b1;
    @(posedge clk_i); #2;
    ba_rd_i[2] = 1'b0;
    repeat (3) @(posedge clk_i);
    #2;
    check("midrst_dok_live", ba_dok_o, 4'b0100);
    rst_ni = 1'b0;
    #1;
    check("midrst_ctrl", {ba_ack_o, ba_dst_o, ba_dok_o, ba_rdy_o, prog_rdy_o, mem_rd_o, mem_we_o, mem_wmask_o}, 64'h0);
    check("midrst_data", {data_read_o, mem_addr_o, mem_din_o}, 64'h0);
    check("midrst_state", dbg_state_o, 3'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk_i);
      if ((ba_rdy_o | ba_dok_o | ba_ack_o) != 4'b0) cnt++;
    end
    check("midrst_no_resp", 64'(cnt), 64'(0));

    // round-robin with all four requests held
    @(posedge clk_i); #1;
    for (int b = 0; b < 4; b++) set_ba_addr(b, 22'h001000 + 22'(16 * b));
    for (int i = 0; i < 5; i++) begin
      int b;
      b = i % 4;
      push_read(b, {2'(b), 22'h001000 + 22'(16 * b)}, {2'(b), 22'h001001 + 22'(16 * b)});
      order[i] = -1;
      gap[i] = -1;
    end
    ba_rd_i = 4'b1111;
    nack = 0; nrdy = 0; last_rdy = -100;
    for (int k = 0; k < 300 && nrdy < 5; k++) begin
      @(negedge clk_i);
      if (ba_ack_o != 4'b0) begin
        if (nack < 5) begin
          order[nack] = oh2i(ba_ack_o);
          gap[nack] = cyc - last_rdy;
        end
        nack++;
        if (nack == 5) ba_rd_i = 4'b0;
      end
      if (ba_rdy_o != 4'b0) begin
        last_rdy = cyc;
        nrdy++;
      end
    end
    ba_rd_i = 4'b0;
    check("rr_acks", 64'(nack), 64'(5));
    for (int i = 0; i < 5; i++) check("rr_order", 64'(order[i]), 64'(i % 4));
    for (int i = 1; i < 5; i++) check("rr_ack_after_rdy", 64'(gap[i]), 64'(2));
    repeat (2) @(negedge clk_i);

    // bank-0 write
    @(posedge clk_i); #1;
    exp_wr_q.push_back({2'b00, 22'h0ABCDE, 16'hBEEF, 2'b01});
    ba0_addr_i = 22'h0ABCDE;
    ba0_din_i = 16'hBEEF;
    ba0_din_m_i = 2'b01;
    ba_wr_i = 1'b1;
    ba_rd_i[0] = 1'b1;
    t0 = cyc;
    ack_c = -1; rdy_c = -1; dok_seen = 0; ack_v = '0; rdy_v = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      if (ba_ack_o != 4'b0 && ack_c < 0) begin
        ack_c = cyc - t0;
        ack_v = ba_ack_o;
        ba_rd_i[0] = 1'b0;
        ba_wr_i = 1'b0;
      end
      if (ba_rdy_o != 4'b0 && rdy_c < 0) begin
        rdy_c = cyc - t0;
        rdy_v = ba_rdy_o;
      end
      if (ba_dok_o != 4'b0 || ba_dst_o != 4'b0) dok_seen++;
    end
    ba_rd_i[0] = 1'b0;
    ba_wr_i = 1'b0;
    check("bwr_ack_cycle", 64'(ack_c), 64'(1));
    check("bwr_ack_vec", ack_v, 4'b0001);
    check("bwr_rdy_cycle", 64'(rdy_c), 64'(2));
    check("bwr_rdy_vec", rdy_v, 4'b0001);
    check("bwr_no_dok", 64'(dok_seen), 64'(0));
    check("bwr_written", 64'(exp_wr_q.size()), 64'(0));

    // download: six writes, WE held, loader drops WE one edge late
    downloading_i = 1'b1;
    prog_ba_i = 2'b01;
    nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      got = 0;
      @(posedge clk_i); #1;
      pa = 22'h000010 + 22'(i);
      pd = 16'($urandom_range(0, 65535));
      pm = (i % 2 == 0) ? 2'b10 : 2'b01;
      prog_addr_i = pa;
      prog_data_i = pd;
      prog_mask_i = pm;
      exp_wr_q.push_back({2'b01, pa, pd, pm});
      prog_we_i = 1'b1;
      for (int k = 0; k < 10 && got == 0; k++) begin
        @(negedge clk_i);
        if (prog_rdy_o) begin
          got = 1;
          rdy_t[nrdy] = cyc;
          nrdy++;
        end
      end
      check("dl_rdy_seen", 64'(got), 64'(1));
    end
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    prog_we_i = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (prog_rdy_o) cnt++;
    end
    check("dl_rdy_count", 64'(nrdy + cnt), 64'(6));
    for (int i = 1; i < 6; i++) check("dl_spacing", 64'(rdy_t[i] - rdy_t[i-1]), 64'(3));
    check("dl_written", 64'(exp_wr_q.size()), 64'(0));

    // priority: download blocks bank requests, PROG write still serviced
    @(posedge clk_i); #1;
    ba1_addr_i = 22'h000200;
    ba_rd_i = 4'b0010;
    pd = 16'($urandom_range(0, 65535));
    prog_addr_i = 22'h000020;
    prog_data_i = pd;
    prog_mask_i = 2'b00;
    prog_ba_i = 2'b01;
    exp_wr_q.push_back({2'b01, 22'h000020, pd, 2'b00});
    prog_we_i = 1'b1;
    cnt = 0; got = 0; t0 = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      if (ba_ack_o != 4'b0) cnt++;
      if (got == 1 && cyc == t0 + 1) prog_we_i = 1'b0;
      if (prog_rdy_o && got == 0) begin
        got = 1;
        t0 = cyc;
      end
    end
    prog_we_i = 1'b0;
    check("prio_prog_done", 64'(got), 64'(1));
    check("prio_no_bank_ack", 64'(cnt), 64'(0));
    check("prio_written", 64'(exp_wr_q.size()), 64'(0));
    @(posedge clk_i); #1;
    push_read(1, 24'h400200, 24'h400201);
    downloading_i = 1'b0;
    t0 = cyc;
    ack_c = -1; rdy_c = -1; ack_v = '0;
    for (int k = 0; k < 20 && rdy_c < 0; k++) begin
      @(negedge clk_i);
      if (ba_ack_o != 4'b0 && ack_c < 0) begin
        ack_c = cyc - t0;
        ack_v = ba_ack_o;
        ba_rd_i = 4'b0;
      end
      if (ba_rdy_o != 4'b0) rdy_c = cyc - t0;
    end
    ba_rd_i = 4'b0;
    check("prio_ack_cycle", 64'(ack_c), 64'(1));
    check("prio_ack_vec", ack_v, 4'b0010);
    check("prio_rdy_cycle", 64'(rdy_c), 64'(LAT + BURST + 1));

    repeat (6) @(negedge clk_i);
    check("rd_queue_drained", 64'(exp_rd_q.size()), 64'(0));
    check("wr_queue_drained", 64'(exp_wr_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snowbro2_bank_resp.md
Name: snowbro2_bank_resp

Overview:
- Memory-side responder for the snowbro2 SDRAM request interface.
- Services two kinds of traffic:
  - Download writes on PROG_* from the ROM loader.
  - Four-bank read requests on BA_* from the ROM slot multiplexers, plus bank-0 writes.
- Serialises all traffic onto a single synchronous, fixed-latency, 16-bit memory port.
- Sits between the game SDRAM mapper and the memory (BRAM/DDR bridge builds and simulation).

Parameters:
- MEM_LAT, 2: cycles from MEM_RD high to MEM_DOUT valid (1..4).
- BURST, 2: words returned per read request (1 or 2; 2 matches 32-bit/double slots).

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  reset, asynchronous, active-low.
- DOWNLOADING  in  1  ROM download in progress.
- PROG_ADDR  in  22  download word address.
- PROG_DATA  in  16  download data.
- PROG_MASK  in  2  byte mask; 1 = byte NOT written. bit1 = [15:8], bit0 = [7:0].
- PROG_BA  in  2  download bank.
- PROG_WE  in  1  download write request (level).
- PROG_RDY  out  1  download write done (pulse).
- BA0_ADDR, BA1_ADDR, BA2_ADDR, BA3_ADDR  in  22 each  per-bank word address.
- BA_RD  in  4  per-bank request (level).
- BA_WR  in  1  qualifies a BA_RD[0] request as a write.
- BA0_DIN  in  16  bank-0 write data.
- BA0_DIN_M  in  2  bank-0 write mask; 1 = masked.
- BA_ACK  out  4  request accepted (pulse).
- BA_DST  out  4  first data word on DATA_READ.
- BA_DOK  out  4  valid data word on DATA_READ.
- BA_RDY  out  4  transaction complete (pulse).
- DATA_READ  out  16  read data.
- MEM_ADDR  out  24  {bank, word address}.
- MEM_RD  out  1  memory read strobe.
- MEM_WE  out  1  memory write strobe.
- MEM_DIN  out  16  memory write data.
- MEM_WMASK  out  2  memory write mask; 1 = masked.
- MEM_DOUT  in  16  memory read data.

Behaviour:
- Reset (async, RESET_N low): all outputs 0; FSM in IDLE; round-robin pointer = 0; latency pipeline cleared. An in-flight transaction is abandoned with no ACK/RDY.
- FSM states: IDLE, PWR, BWR, RD_ISSUE, RD_DRAIN.
- Arbitration in IDLE, evaluated each cycle, highest priority first:
  1. PROG_WE, only when not blanked.
  2. Bank requests, round-robin starting at pointer. Pointer advances to granted bank + 1 (mod 4).
- While DOWNLOADING = 1, BA_RD is ignored entirely.
- PROG write (IDLE -> PWR, one cycle):
  - MEM_WE = 1, MEM_ADDR = {PROG_BA, PROG_ADDR}, MEM_DIN = PROG_DATA, MEM_WMASK = PROG_MASK.
  - PROG_RDY pulses in the same cycle; FSM returns to IDLE.
  - PROG_WE is blanked for the cycle after PROG_RDY, because the loader drops WE one edge late. Back-to-back writes are therefore accepted at most every 3 cycles.
- Bank-0 write (BA_RD[0] & BA_WR granted -> BWR, one cycle):
  - BA_ACK[0] pulses; MEM_WE with BA0_DIN/BA0_DIN_M.
  - BA_RDY[0] pulses in the next cycle. No DST/DOK.
- Read grant of bank b (IDLE -> RD_ISSUE):
  - Address captured at grant; requester may change it after ACK.
  - BA_ACK[b] pulses the first RD_ISSUE cycle.
  - MEM_RD high for BURST consecutive cycles. Addresses are base, base+1; the 22-bit word address wraps to 0 inside the same bank.
  - Then RD_DRAIN until the last word is delivered.
- Read data:
  - DATA_READ is MEM_DOUT registered, so a word is output MEM_LAT+1 cycles after its MEM_RD.
  - BA_DOK[b] is high for each word.
  - BA_DST[b] is high with word 0 only.
  - BA_RDY[b] is high with the last word. With BURST=1, DST, DOK and RDY coincide.
- Exactly one of ACK/DST/DOK/RDY bit groups refers to the active bank. Other bits stay 0.
- Return to IDLE: the cycle after RDY, so a new grant can occur the cycle after that.
- Request withdrawn before ACK: no grant. Request held after RDY: treated as a new request.
- DOWNLOADING rising during a read: the read completes normally.

Test Plan:
- Reset mid-read: assert RESET_N low during RD_DRAIN -> all outputs 0 immediately; no RDY pulse after release.
- Download: 6 PROG writes, PROG_WE held until PROG_RDY, ADDR=0x000010.., BA=1, MASK alternating 10/01 -> MEM_WE with MEM_ADDR=0x400010.. and masks passed through; PROG_RDY exactly once each; no write during blank cycle.
- Single read: MEM_LAT=2, BURST=2, BA_RD[1] high at cycle 0, BA1_ADDR=0x3FFFFF:
  - ACK[1] at cycle 1; MEM_RD cycles 1–2 at 0x7FFFFF then 0x400000 (wrap).
  - DST/DOK at cycle 4; DOK/RDY at cycle 5.
- Round-robin: BA_RD=4'b1111 held -> grants in order 0,1,2,3,0, each ACK only after the prior RDY.
- Bank-0 write: BA_RD[0]=1, BA_WR=1, DIN=0xBEEF, M=2'b01 -> ACK[0] then RDY[0] next cycle; MEM_WE with WMASK=01; DOK stays 0.
- Priority: DOWNLOADING=1 with BA_RD=4'b0010 and PROG_WE -> only the PROG write is serviced; BA_ACK stays 0 until DOWNLOADING falls.
